// File: rtl/dm_pkg.sv
// Shared access-type codes and FSM encoding for the data-memory responder.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dm_state_e;

  // Codes 101..111 are reserved and complete with an error.
  function automatic logic dm_type_valid(input logic [2:0] t);
    return t <= DM_BYTE_U;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane merge for stores and lane extraction/extension for loads.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_word,
  output logic        misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = lane[1] ? old_word[31:16] : old_word[15:0];
  assign byte_sel = old_word[8*lane +: 8];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    store_word = old_word;
    load_word  = '0;
    misalign   = 1'b0;
    unique case (dm_type)
      DM_WORD: begin
        store_word = wdata;
        load_word  = old_word;
        misalign   = (lane != 2'b00);
      end
      DM_HALF, DM_HALF_U: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
        load_word = (dm_type == DM_HALF) ? {{16{half_sel[15]}}, half_sel}
                                         : {16'h0000, half_sel};
        misalign  = lane[0];
      end
      DM_BYTE, DM_BYTE_U: begin
        store_word[8*lane +: 8] = wdata[7:0];
        load_word = (dm_type == DM_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'h000000, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: latches one load/store, waits WAIT_STATES cycles,
// accesses an internal word array and pulses mio_ready with the result.
module dmem_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        mio_ready,
  output logic        mio_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  dm_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  capture;
  logic                  do_access;

  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  req_w;
  logic [2:0]            req_type;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           old_word;
  logic [31:0]           store_word;
  logic [31:0]           load_word;
  logic                  misalign;
  logic                  acc_err;

  // Address bits above the array are ignored, so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    mio_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mio_req) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = WAIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        do_access = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        mio_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx      = req_addr[ADDR_WIDTH+1:2];
  assign old_word = mem[idx];
  assign acc_err  = misalign || !dm_type_valid(req_type);

  dm_lane_align u_align (
    .dm_type    (req_type),
    .lane       (req_addr[1:0]),
    .old_word   (old_word),
    .wdata      (req_wdata),
    .store_word (store_word),
    .load_word  (load_word),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_w     <= 1'b0;
      req_type  <= DM_WORD;
      rdata     <= '0;
      mio_err   <= 1'b0;
    end else begin
      if (capture) begin
        req_addr  <= addr[ADDR_WIDTH+1:0];
        req_wdata <= wdata;
        req_w     <= mem_w;
        req_type  <= dm_type;
      end
      if (do_access) begin
        mio_err <= acc_err;
        rdata   <= (acc_err || req_w) ? 32'h0 : load_word;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_access && req_w && !acc_err) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic        req2, req0;
  logic [31:0] rdata2, rdata0;
  logic        ready2, ready0;
  logic        err2, err0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_ws2 (
    .clk       (clk),
    .reset     (reset),
    .mio_req   (req2),
    .mem_w     (mem_w),
    .addr      (addr),
    .wdata     (wdata),
    .dm_type   (dm_type),
    .rdata     (rdata2),
    .mio_ready (ready2),
    .mio_err   (err2)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
    .clk       (clk),
    .reset     (reset),
    .mio_req   (req0),
    .mem_w     (mem_w),
    .addr      (addr),
    .wdata     (wdata),
    .dm_type   (dm_type),
    .rdata     (rdata0),
    .mio_ready (ready0),
    .mio_err   (err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Drives one request just after an edge and waits for the completion pulse.
  task automatic xact(input string tag, input bit sel0, input logic w,
                      input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t,
                      input int lat, output logic [31:0] rd, output logic er);
    int   n;
    bit   seen;
    logic rdy;
    mem_w = w; addr = a; wdata = wd; dm_type = t;
    if (sel0) req0 = 1'b1; else req2 = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); n++; #1;
      rdy = sel0 ? ready0 : ready2;
      if (rdy) seen = 1'b1;
    end
    rd = sel0 ? rdata0 : rdata2;
    er = sel0 ? err0 : err2;
    req0 = 1'b0; req2 = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
    rdy = sel0 ? ready0 : ready2;
    check({tag, " one-cycle pulse"}, 32'(rdy), 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    reset = 1'b1; req2 = 1'b0; req0 = 1'b0;
    mem_w = 1'b0; addr = '0; wdata = '0; dm_type = DM_WORD;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset rdata",  rdata2, 32'h0);
    check("reset ready",  32'(ready2), 32'h0);
    check("reset err",    32'(err2), 32'h0);
    check("reset ready0", 32'(ready0), 32'h0);

    // Word round trip
    xact("sw 10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, DM_WORD, 4, rd, er);
    check("sw 10 rdata", rd, 32'h0);
    check("sw 10 err", 32'(er), 32'h0);
    xact("lw 10", 1'b0, 1'b0, 32'h10, 32'h0, DM_WORD, 4, rd, er);
    check("lw 10 rdata", rd, 32'hDEADBEEF);
    check("lw 10 err", 32'(er), 32'h0);
    check("rdata held after resp", rdata2, 32'hDEADBEEF);

    // Extension
    xact("lb 13", 1'b0, 1'b0, 32'h13, 32'h0, DM_BYTE, 4, rd, er);
    check("lb 13 rdata", rd, 32'hFFFFFFDE);
    xact("lbu 13", 1'b0, 1'b0, 32'h13, 32'h0, DM_BYTE_U, 4, rd, er);
    check("lbu 13 rdata", rd, 32'h000000DE);
    xact("lh 10", 1'b0, 1'b0, 32'h10, 32'h0, DM_HALF, 4, rd, er);
    check("lh 10 rdata", rd, 32'hFFFFBEEF);
    xact("lhu 12", 1'b0, 1'b0, 32'h12, 32'h0, DM_HALF_U, 4, rd, er);
    check("lhu 12 rdata", rd, 32'h0000DEAD);

    // Partial stores
    xact("sb 11", 1'b0, 1'b1, 32'h11, 32'hFFFFFF5A, DM_BYTE, 4, rd, er);
    check("sb 11 err", 32'(er), 32'h0);
    xact("lw after sb", 1'b0, 1'b0, 32'h10, 32'h0, DM_WORD, 4, rd, er);
    check("lw after sb rdata", rd, 32'hDEAD5AEF);
    xact("sh 12", 1'b0, 1'b1, 32'h12, 32'hABCD1234, DM_HALF, 4, rd, er);
    xact("lw after sh", 1'b0, 1'b0, 32'h10, 32'h0, DM_WORD, 4, rd, er);
    check("lw after sh rdata", rd, 32'h12345AEF);

    // Errors: misaligned word load, misaligned half store, reserved type
    xact("lw 12 misal", 1'b0, 1'b0, 32'h12, 32'h0, DM_WORD, 4, rd, er);
    check("lw 12 misal err", 32'(er), 32'h1);
    check("lw 12 misal rdata", rd, 32'h0);
    xact("sh 11 misal", 1'b0, 1'b1, 32'h11, 32'h0000FFFF, DM_HALF, 4, rd, er);
    check("sh 11 misal err", 32'(er), 32'h1);
    check("sh 11 misal rdata", rd, 32'h0);
    xact("lw 10 pre-bad", 1'b0, 1'b0, 32'h10, 32'h0, DM_WORD, 4, rd, er);
    xact("type 111", 1'b0, 1'b1, 32'h10, 32'h00000000, 3'b111, 4, rd, er);
    check("type 111 err", 32'(er), 32'h1);
    check("type 111 rdata", rd, 32'h0);
    xact("lw 10 after errs", 1'b0, 1'b0, 32'h10, 32'h0, DM_WORD, 4, rd, er);
    check("lw 10 after errs rdata", rd, 32'h12345AEF);
    check("lw 10 after errs err", 32'(er), 32'h0);

    // Zero wait states and address wrap
    xact("ws0 sw 1000", 1'b1, 1'b1, 32'h1000, 32'hA5A5A5A5, DM_WORD, 2, rd, er);
    check("ws0 sw err", 32'(er), 32'h0);
    xact("ws0 lw 0", 1'b1, 1'b0, 32'h0, 32'h0, DM_WORD, 2, rd, er);
    check("ws0 lw 0 rdata", rd, 32'hA5A5A5A5);

    // Reset while waiting aborts the store
    xact("sw 20 seed", 1'b0, 1'b1, 32'h20, 32'h55667788, DM_WORD, 4, rd, er);
    mem_w = 1'b1; addr = 32'h20; wdata = 32'h11111111; dm_type = DM_WORD;
    req2 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; req2 = 1'b0;
    #3 reset = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (ready2) pulses++;
      end
      check("abort no ready", 32'(pulses), 32'h0);
    end
    check("abort rdata reset", rdata2, 32'h0);
    xact("lw 20 after abort", 1'b0, 1'b0, 32'h20, 32'h0, DM_WORD, 4, rd, er);
    check("lw 20 after abort rdata", rd, 32'h55667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
